// File: rtl/adc_sampler_pkg.sv
// Shared definitions for the ADC acquisition path: sequencer state encoding and
// the default conversion geometry also used by TemperatureCalculator's adc_data input.
package adc_sampler_pkg;

  localparam int ADC_DATA_W   = 16;
  localparam int ADC_CLK_DIV  = 4;
  localparam int ADC_AVG_LOG2 = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    DONE     = 3'd4
  } adc_state_t;

endpackage

// File: rtl/adc_spi_rx.sv
// Single-conversion serial receiver: sclk divider, cs_n framing and MSB-first
// shift register, started by a one-cycle start and reporting done at the end of CS_HOLD.
module adc_spi_rx
  import adc_sampler_pkg::*;
#(
  parameter int DATA_W  = ADC_DATA_W,
  parameter int CLK_DIV = ADC_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sdo,
  output logic              cs_n,
  output logic              sclk,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic              done,
  output adc_state_t        phase_next
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(2 * DATA_W);

  adc_state_t        phase_q, phase_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              half_end;
  logic              bit_last;

  assign half_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_last = (bit_q == BIT_W'(2 * DATA_W - 1));

  // Kept outside the next-state block so the parent can feed start back from done
  // without forming a combinational loop through one process.
  assign word_valid = (phase_q == SHIFT) && half_end && bit_last;
  assign done       = (phase_q == CS_HOLD) && half_end;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
    phase_d = phase_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    shift_d = shift_q;

    if (phase_q != IDLE) begin
      div_d = half_end ? '0 : div_q + 1'b1;
    end

    case (phase_q)
      IDLE: begin
        if (start) begin
          phase_d = CS_SETUP;
          cs_n_d  = 1'b0;
          div_d   = '0;
        end
      end
      CS_SETUP: begin
        if (half_end) begin
          phase_d = SHIFT;
          sclk_d  = 1'b1;
          bit_d   = '0;
          shift_d = {shift_q[DATA_W-2:0], sdo};
        end
      end
      SHIFT: begin
        if (half_end) begin
          if (bit_last) begin
            phase_d = CS_HOLD;
            cs_n_d  = 1'b1;
          end else begin
            bit_d  = bit_q + 1'b1;
            sclk_d = ~sclk_q;
            // Capture on the edge that raises sclk; the ADC updates sdo on the fall.
            if (!sclk_q) begin
              shift_d = {shift_q[DATA_W-2:0], sdo};
            end
          end
        end
      end
      CS_HOLD: begin
        if (half_end) begin
          if (start) begin
            phase_d = CS_SETUP;
            cs_n_d  = 1'b0;
          end else begin
            phase_d = IDLE;
          end
        end
      end
      default: phase_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      shift_q <= '0;
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      shift_q <= shift_d;
    end
  end

  assign cs_n       = cs_n_q;
  assign sclk       = sclk_q;
  assign word       = shift_q;
  assign phase_next = phase_d;

endmodule

// File: rtl/adc_sampler.sv
// Averaging front end: runs 2^AVG_LOG2 serial conversions back to back and
// presents their truncated mean on adc_data with a one-cycle data_valid.
module adc_sampler
  import adc_sampler_pkg::*;
#(
  parameter int DATA_W   = ADC_DATA_W,
  parameter int CLK_DIV  = ADC_CLK_DIV,
  parameter int AVG_LOG2 = ADC_AVG_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              adc_sdo,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] adc_data,
  output logic              data_valid,
  output logic              busy
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  adc_state_t        state_q, state_d;
  logic [CNT_W-1:0]  conv_q, conv_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic              rx_start;
  logic              rx_done;
  logic              rx_word_valid;
  logic [DATA_W-1:0] rx_word;
  adc_state_t        rx_phase_next;
  logic              last_conv;

  assign last_conv = (conv_q == CNT_W'(N - 1));
  assign rx_start  = ((state_q == IDLE) && start) || (rx_done && !last_conv);

  adc_spi_rx #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (rx_start),
    .sdo        (adc_sdo),
    .cs_n       (adc_cs_n),
    .sclk       (adc_sclk),
    .word       (rx_word),
    .word_valid (rx_word_valid),
    .done       (rx_done),
    .phase_next (rx_phase_next)
  );

  always_comb begin
    state_d = state_q;
    conv_d  = conv_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CS_SETUP;
          conv_d  = '0;
          acc_d   = '0;
        end
      end
      CS_SETUP, SHIFT, CS_HOLD: begin
        // The receiver owns the phase timing; this FSM follows it and decides when to stop.
        state_d = rx_phase_next;
        if (rx_word_valid) begin
          acc_d = acc_q + ACC_W'(rx_word);
        end
        if (rx_done) begin
          if (last_conv) begin
            state_d = DONE;
            data_d  = DATA_W'(acc_q >> AVG_LOG2);
            valid_d = 1'b1;
          end else begin
            conv_d = conv_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      conv_q  <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      conv_q  <= conv_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign adc_data   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Scoreboard bench for adc_sampler: one instance without averaging and one
// averaging four conversions, each driven by a behavioural serial ADC model.
module tb_adc_sampler;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic        a_sdo = 1'b0, b_sdo = 1'b0;
  logic        a_cs_n, a_sclk, a_valid, a_busy;
  logic        b_cs_n, b_sclk, b_valid, b_busy;
  logic [15:0] a_data, b_data;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t        exp_a[$];
  exp_t        exp_b[$];
  logic [15:0] a_words[$];
  logic [15:0] b_words[$];
  logic [15:0] a_sreg, b_sreg;
  int a_rise_cnt = 0, b_rise_cnt = 0;
  int a_windows  = 0, b_windows  = 0;
  int a_valid_cnt = 0, b_valid_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_sampler #(.DATA_W(16), .CLK_DIV(2), .AVG_LOG2(0)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_a),
    .adc_sdo    (a_sdo),
    .adc_cs_n   (a_cs_n),
    .adc_sclk   (a_sclk),
    .adc_data   (a_data),
    .data_valid (a_valid),
    .busy       (a_busy)
  );

  adc_sampler #(.DATA_W(16), .CLK_DIV(2), .AVG_LOG2(2)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .adc_sdo    (b_sdo),
    .adc_cs_n   (b_cs_n),
    .adc_sclk   (b_sclk),
    .adc_data   (b_data),
    .data_valid (b_valid),
    .busy       (b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ADC models: load the next word when cs_n falls, present MSB, advance on each sclk fall.
  always @(negedge a_cs_n) begin
    a_sreg = (a_words.size() > 0) ? a_words.pop_front() : 16'h0000;
    a_sdo = a_sreg[15];
    a_rise_cnt = 0;
    a_windows++;
  end
  always @(posedge a_sclk) if (!a_cs_n) a_rise_cnt++;
  always @(negedge a_sclk) if (!a_cs_n) begin
    a_sreg = a_sreg << 1;
    a_sdo = a_sreg[15];
  end

  always @(negedge b_cs_n) begin
    b_sreg = (b_words.size() > 0) ? b_words.pop_front() : 16'h0000;
    b_sdo = b_sreg[15];
    b_rise_cnt = 0;
    b_windows++;
  end
  always @(posedge b_sclk) if (!b_cs_n) b_rise_cnt++;
  always @(negedge b_sclk) if (!b_cs_n) begin
    b_sreg = b_sreg << 1;
    b_sdo = b_sreg[15];
  end

  // Monitors: every data_valid must match the oldest pending expectation, in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (a_valid === 1'b1) begin
      a_valid_cnt++;
      if (exp_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected: data_valid with adc_data=%0h, none required", a_data);
      end else begin
        e = exp_a.pop_front();
        check("a_data", 32'(a_data), 32'(e.data));
        check("a_latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_valid === 1'b1) begin
      b_valid_cnt++;
      if (exp_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected: data_valid with adc_data=%0h, none required", b_data);
      end else begin
        e = exp_b.pop_front();
        check("b_data", 32'(b_data), 32'(e.data));
        check("b_latency", cyc, e.cyc);
      end
    end
  end

  task automatic issue_a(input logic [15:0] exp, input int lat);
    exp_a.push_back('{exp, cyc + 1 + lat});
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic issue_b(input logic [15:0] exp, input int lat);
    exp_b.push_back('{exp, cyc + 1 + lat});
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_a.size() + exp_b.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int w0;
    int n;
    int c;

    // Reset held with start asserted: everything stays at reset values.
    rst_n   = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_a", 32'({a_cs_n, a_sclk, a_valid, a_busy, a_data}), 32'h80000);
      check("rst_b", 32'({b_cs_n, b_sclk, b_valid, b_busy, b_data}), 32'h80000);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    rst_n   = 1'b1;
    repeat (2) @(negedge clk);

    // Single conversion, no averaging: (2*16+2)*2 = 68 cycles.
    w0 = a_windows;
    a_words.push_back(16'h0001);
    issue_a(16'h0001, 68);
    drain("a_single_drain", 200);
    check("a_single_windows", 32'(a_windows - w0), 32'd1);
    check("a_single_sclk_rises", 32'(a_rise_cnt), 32'd16);
    check("a_idle_after", 32'({a_cs_n, a_sclk, a_busy}), 32'b100);

    a_words.push_back(16'h8000);
    issue_a(16'h8000, 68);
    drain("a_msb_drain", 200);
    a_words.push_back(16'hFFFF);
    issue_a(16'hFFFF, 68);
    drain("a_ones_drain", 200);
    check("a_data_hold", 32'(a_data), 32'h0000FFFF);

    // Average of 100..103 = 406 >> 2 = 101, latency 4*68 = 272.
    w0 = b_windows;
    b_words.push_back(16'd100);
    b_words.push_back(16'd101);
    b_words.push_back(16'd102);
    b_words.push_back(16'd103);
    issue_b(16'd101, 272);
    drain("b_avg_drain", 400);
    check("b_avg_windows", 32'(b_windows - w0), 32'd4);
    check("b_avg_sclk_rises", 32'(b_rise_cnt), 32'd16);

    // Full scale must not wrap.
    for (int i = 0; i < 4; i++) b_words.push_back(16'hFFFF);
    issue_b(16'hFFFF, 272);
    drain("b_full_drain", 400);

    // Start held high: 1001 then (0+0+0+3)>>2 = 0, spaced 272+2 cycles.
    for (int i = 0; i < 4; i++) b_words.push_back(16'(1000 + i));
    b_words.push_back(16'd0);
    b_words.push_back(16'd0);
    b_words.push_back(16'd0);
    b_words.push_back(16'd3);
    c = cyc;
    exp_b.push_back('{16'd1001, c + 1 + 272});
    exp_b.push_back('{16'd0, c + 1 + 272 + 274});
    w0 = b_valid_cnt;
    start_b = 1'b1;
    n = 0;
    while (b_valid_cnt == w0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("b_held_first_seen", 32'(b_valid_cnt - w0), 32'd1);
    repeat (5) @(negedge clk);
    start_b = 1'b0;
    drain("b_held_drain", 400);
    check("b_held_count", 32'(b_valid_cnt - w0), 32'd2);

    // Repeated start pulses while busy yield one result: (10+20+30+41)>>2 = 25.
    w0 = b_valid_cnt;
    b_words.push_back(16'd10);
    b_words.push_back(16'd20);
    b_words.push_back(16'd30);
    b_words.push_back(16'd41);
    issue_b(16'd25, 272);
    for (int i = 0; i < 3; i++) begin
      repeat (40) @(negedge clk);
      check("b_busy_during", 32'(b_busy), 32'd1);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
    end
    drain("b_pulse_drain", 400);
    repeat (20) @(negedge clk);
    check("b_pulse_count", 32'(b_valid_cnt - w0), 32'd1);
    check("b_data_hold", 32'(b_data), 32'd25);

    // Abort around bit 7 of the first conversion: outputs drop at once, no result.
    w0 = b_valid_cnt;
    for (int i = 0; i < 4; i++) b_words.push_back(16'h1234);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (b_rise_cnt < 8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b_abort_reached_bit7", 32'(b_rise_cnt), 32'd8);
    check("b_abort_sclk_high", 32'({b_cs_n, b_sclk}), 32'b01);
    rst_n = 1'b0;
    #1;
    check("b_abort_outputs", 32'({b_cs_n, b_sclk, b_valid, b_busy, b_data}), 32'h80000);
    check("a_abort_data", 32'(a_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b_words.delete();
    repeat (2) @(negedge clk);
    check("b_abort_no_valid", 32'(b_valid_cnt - w0), 32'd0);
    for (int i = 0; i < 4; i++) b_words.push_back(16'h8001);
    issue_b(16'h8001, 272);
    drain("b_after_abort_drain", 400);

    check("a_total_results", 32'(a_valid_cnt), 32'd3);
    check("b_total_results", 32'(b_valid_cnt), 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
